// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction encoder: field types,
// word bit positions and the encoder run-state enum.
package isa_pkg;

    typedef enum logic [1:0] {
        FT_REG    = 2'b00,
        FT_MEM    = 2'b01,
        FT_BRANCH = 2'b10,
        FT_KERNEL = 2'b11
    } funtype_e;

    // CMP is REG with this funcode; it shares the REG layout.
    localparam logic [1:0] FC_CMP = 2'b11;

    localparam int unsigned FUNTYPE_LSB = 30;
    localparam int unsigned FUNTYPE_W   = 2;
    localparam int unsigned FUNCODE_LSB = 28;
    localparam int unsigned FUNCODE_W   = 2;
    localparam int unsigned REG_W       = 4;
    localparam int unsigned RD_LSB      = 24;
    localparam int unsigned RS_LSB      = 20;
    localparam int unsigned RX_LSB      = 16;
    localparam int unsigned IMM28_W     = 28;
    localparam int unsigned SELIMM_BIT  = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_DRAIN = 2'b10,
        S_DONE  = 2'b11
    } enc_state_e;

endpackage

// File: rtl/instruction_packer.sv
// Combinational field packer: builds one 32-bit ISA word and flags
// whether the immediate fits its slot.
// Ports: i_funtype/i_funcode/i_rd/i_rs/i_rx/i_imm/i_selimm in,
//        o_word (packed word), o_imm_ok (immediate in range) out.
module instruction_packer
    import isa_pkg::*;
#(
    parameter int bus = 32
) (
    input  logic [1:0]     i_funtype,
    input  logic [1:0]     i_funcode,
    input  logic [3:0]     i_rd,
    input  logic [3:0]     i_rs,
    input  logic [3:0]     i_rx,
    input  logic [bus-1:0] i_imm,
    input  logic           i_selimm,
    output logic [31:0]    o_word,
    output logic           o_imm_ok
);

    logic [3:0] w_opb;

    // Operand B slot carries either rs or the 4-bit immediate.
    assign w_opb = i_selimm ? i_imm[REG_W-1:0] : i_rs;

    always_comb begin
        o_word   = '0;
        o_imm_ok = 1'b1;
        o_word[FUNTYPE_LSB +: FUNTYPE_W] = i_funtype;
        o_word[FUNCODE_LSB +: FUNCODE_W] = i_funcode;
        if (i_funtype == FT_BRANCH) begin
            o_word[IMM28_W-1:0] = i_imm[IMM28_W-1:0];
            o_imm_ok = ((i_imm >> IMM28_W) == '0);
        end else begin
            o_word[RD_LSB +: REG_W] = i_rd;
            o_word[RS_LSB +: REG_W] = w_opb;
            o_word[RX_LSB +: REG_W] = i_rx;
            o_word[SELIMM_BIT]      = i_selimm;
            o_imm_ok = !i_selimm || ((i_imm >> REG_W) == '0);
        end
    end

endmodule

// File: rtl/instruction_encoder.sv
// Streams packed instruction words into instruction memory at
// consecutive addresses behind a valid/ready field handshake.
// Ports: clk/rst, start+base_addr (run control), in_valid/in_ready
//        with field inputs, wr_en/wr_addr/wr_data/wr_ready memory port,
//        done/full/err status and count of completed writes.
module instruction_encoder
    import isa_pkg::*;
#(
    parameter int bus   = 32,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [AW-1:0]  base_addr,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     funtype,
    input  logic [1:0]     funcode,
    input  logic [3:0]     rd,
    input  logic [3:0]     rs,
    input  logic [3:0]     rx,
    input  logic [bus-1:0] imm,
    input  logic           selimm,
    input  logic           last,
    output logic           wr_en,
    output logic [AW-1:0]  wr_addr,
    output logic [31:0]    wr_data,
    input  logic           wr_ready,
    output logic           done,
    output logic           full,
    output logic           err,
    output logic [AW:0]    count
);

    localparam logic [AW:0]   LAST_CLAIM = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH-1);
    localparam logic [AW:0]   ONE_W      = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_A      = AW'(1);

    enc_state_e  r_state;
    enc_state_e  w_next;
    logic        r_wr_en;
    logic [AW-1:0] r_wr_addr;
    logic [31:0] r_wr_data;
    logic [AW:0] r_count;
    logic [AW:0] r_issue;
    logic        r_err;
    logic        r_full;

    logic [31:0] w_word;
    logic        w_imm_ok;
    logic        w_in_ready;
    logic        w_stall;
    logic        w_claimed;
    logic        w_wr_done;
    logic        w_hit_last;
    logic        w_accept;
    logic        w_load;

    instruction_packer #(
        .bus(bus)
    ) u_packer (
        .i_funtype (funtype),
        .i_funcode (funcode),
        .i_rd      (rd),
        .i_rs      (rs),
        .i_rx      (rx),
        .i_imm     (imm),
        .i_selimm  (selimm),
        .o_word    (w_word),
        .o_imm_ok  (w_imm_ok)
    );

    assign w_stall    = r_wr_en && !wr_ready;
    // Issue pointer one past the top means DEPTH-1 is already taken.
    assign w_claimed  = (r_issue == LAST_CLAIM);
    assign w_wr_done  = r_wr_en && wr_ready;
    assign w_hit_last = w_wr_done && (r_wr_addr == LAST_ADDR);
    assign w_accept   = in_valid && w_in_ready;
    assign w_load     = w_accept && w_imm_ok;

    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        unique case (r_state)
            S_IDLE: begin
            end
            S_RUN: begin
                w_in_ready = !w_stall && !w_claimed;
                if (w_hit_last) begin
                    w_next = S_DONE;
                end else if (w_accept && last) begin
                    // A rejected last leaves nothing pending: the
                    // handshake implies any old word just completed.
                    w_next = w_load ? S_DRAIN : S_DONE;
                end
            end
            S_DRAIN: begin
                if (!r_wr_en || w_wr_done) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
            end
        endcase
        if (start) begin
            w_next = S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_count   <= '0;
            r_issue   <= '0;
            r_err     <= 1'b0;
            r_full    <= 1'b0;
        end else if (start) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= base_addr;
            r_count   <= '0;
            r_issue   <= {1'b0, base_addr};
            r_err     <= 1'b0;
            r_full    <= 1'b0;
        end else begin
            if (w_wr_done) begin
                r_count <= r_count + ONE_W;
            end
            if (w_hit_last) begin
                r_full <= 1'b1;
            end
            if (w_load) begin
                r_wr_en   <= 1'b1;
                r_wr_data <= w_word;
                r_wr_addr <= r_issue[AW-1:0];
                r_issue   <= r_issue + ONE_W;
            end else if (w_wr_done) begin
                r_wr_en <= 1'b0;
                // Park on the top address rather than wrapping.
                if (r_wr_addr != LAST_ADDR) begin
                    r_wr_addr <= r_wr_addr + ONE_A;
                end
            end
            if (w_accept && !w_imm_ok) begin
                r_err <= 1'b1;
            end
        end
    end

    assign in_ready = w_in_ready;
    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign done     = (r_state == S_DONE);
    assign full     = r_full;
    assign err      = r_err;
    assign count    = r_count;

endmodule
